// File: rtl/alu_exec_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_exec_pipe: registered RV32I ALU/branch/jump unit with valid/ready and
// ROB tag. Define ALU_MUL_EN for the iterative MUL/MULH* unit. Rev 1.0
// ---------------------------------------------------------------------------
module alu_exec_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [XLEN-1:0]  in_addr,
  input  logic             in_len32,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_jalr,
  output logic [XLEN-1:0]  out_jaddr
);

  localparam int SH_W = $clog2(XLEN);
  localparam int MSB  = XLEN - 1;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(11);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(16);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(17);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(19);

  logic             out_valid_q, out_zero_q, out_ovf_q, out_jalr_q;
  logic [TAG_W-1:0] out_tag_q;
  logic [XLEN-1:0]  out_result_q, out_jaddr_q;

  logic [XLEN-1:0]  sum, diff, auipc, link, res_d, jaddr_d;
  logic [SH_W-1:0]  shamt;
  logic             lt, ltu, eq, ovf_d, jalr_d, idle, is_mul, accept;

  assign sum   = in_op1 + in_op2;
  assign diff  = in_op1 - in_op2;
  assign auipc = in_addr + in_op2;
  assign link  = in_addr + (in_len32 ? XLEN'(4) : XLEN'(2));
  assign shamt = in_op2[SH_W-1:0];
  assign lt    = $signed(in_op1) < $signed(in_op2);
  assign ltu   = in_op1 < in_op2;
  assign eq    = in_op1 == in_op2;

  always_comb begin
    res_d   = '0;
    ovf_d   = 1'b0;
    jalr_d  = 1'b0;
    jaddr_d = '0;
    case (in_op)
      OP_ADD: begin
        res_d = sum;
        ovf_d = (in_op1[MSB] == in_op2[MSB]) && (sum[MSB] != in_op1[MSB]);
      end
      OP_SUB: begin
        res_d = diff;
        ovf_d = (in_op1[MSB] != in_op2[MSB]) && (diff[MSB] != in_op1[MSB]);
      end
      OP_SLL:  res_d = in_op1 << shamt;
      OP_SLT:  res_d = XLEN'(lt);
      OP_SLTU: res_d = XLEN'(ltu);
      OP_XOR:  res_d = in_op1 ^ in_op2;
      OP_SRL:  res_d = in_op1 >> shamt;
      OP_SRA:  res_d = $unsigned($signed(in_op1) >>> shamt);
      OP_OR:   res_d = in_op1 | in_op2;
      OP_AND:  res_d = in_op1 & in_op2;
      OP_LUI:  res_d = in_op2;
      OP_AUIPC: begin
        res_d = auipc;
        ovf_d = (in_addr[MSB] == in_op2[MSB]) && (auipc[MSB] != in_addr[MSB]);
      end
      OP_JAL:  res_d = link;
      OP_JALR: begin
        res_d   = link;
        jalr_d  = 1'b1;
        jaddr_d = {sum[MSB:1], 1'b0};
      end
      OP_BEQ:  res_d = XLEN'(eq);
      OP_BNE:  res_d = XLEN'(!eq);
      OP_BLT:  res_d = XLEN'(lt);
      OP_BGE:  res_d = XLEN'(!lt);
      OP_BLTU: res_d = XLEN'(ltu);
      OP_BGEU: res_d = XLEN'(!ltu);
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(20);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(22);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(23);
  localparam int CNT_W = SH_W + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   mcand_q, mag1, mag2, mul_res;
  logic [2*XLEN-1:0] prod_q, prod_fix;
  logic [XLEN:0]     step_sum;
  logic [TAG_W-1:0]  mtag_q;
  logic              neg_q, hi_q, sgn1, sgn2;

  assign is_mul = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                  (in_op == OP_MULHSU) || (in_op == OP_MULHU);
  // Multiply magnitudes, then restore the sign on the full 2*XLEN product.
  assign sgn1     = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_op1[MSB];
  assign sgn2     = (in_op == OP_MULH) && in_op2[MSB];
  assign mag1     = sgn1 ? -in_op1 : in_op1;
  assign mag2     = sgn2 ? -in_op2 : in_op2;
  assign step_sum = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_fix = neg_q ? -prod_q : prod_q;
  assign mul_res  = hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  assign idle     = (state_q == S_IDLE);
`else
  assign is_mul = 1'b0;
  assign idle   = 1'b1;
`endif

  assign in_ready = !rst_in && rdy_in && !flush_in && idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_q  <= 1'b0;
      out_tag_q    <= '0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_jalr_q   <= 1'b0;
      out_jaddr_q  <= '0;
`ifdef ALU_MUL_EN
      state_q      <= S_IDLE;
      cnt_q        <= '0;
`endif
    end else if (flush_in) begin
      out_valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
      state_q      <= S_IDLE;
      cnt_q        <= '0;
`endif
    end else if (rdy_in) begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept && !is_mul) begin
        out_valid_q  <= 1'b1;
        out_tag_q    <= in_tag;
        out_result_q <= res_d;
        out_zero_q   <= (res_d == '0);
        out_ovf_q    <= ovf_d;
        out_jalr_q   <= jalr_d;
        out_jaddr_q  <= jaddr_d;
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        state_q <= S_BUSY;
        cnt_q   <= CNT_W'(XLEN);
        mcand_q <= mag1;
        prod_q  <= {{XLEN{1'b0}}, mag2};
        neg_q   <= sgn1 ^ sgn2;
        hi_q    <= (in_op != OP_MUL);
        mtag_q  <= in_tag;
      end else if (state_q == S_BUSY) begin
        if (cnt_q == '0) begin
          state_q      <= S_IDLE;
          out_valid_q  <= 1'b1;
          out_tag_q    <= mtag_q;
          out_result_q <= mul_res;
          out_zero_q   <= (mul_res == '0);
          out_ovf_q    <= 1'b0;
          out_jalr_q   <= 1'b0;
          out_jaddr_q  <= '0;
        end else begin
          prod_q <= {step_sum, prod_q[XLEN-1:1]};
          cnt_q  <= cnt_q - CNT_W'(1);
        end
      end
`endif
    end
  end

  assign out_valid  = out_valid_q;
  assign out_tag    = out_tag_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_ovf    = out_ovf_q;
  assign out_jalr   = out_jalr_q;
  assign out_jaddr  = out_jaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_exec_pipe: directed scoreboard bench for alu_exec_pipe (XLEN=32).
// Multiplier checks are built when ALU_MUL_EN is defined. Rev 1.0
// ---------------------------------------------------------------------------
module tb_alu_exec_pipe;

  localparam logic [4:0] ADD = 5'd0,  SUB = 5'd1,  SLL = 5'd2,  SLT = 5'd3,
                         SLTU = 5'd4, XOR = 5'd5,  SRL = 5'd6,  SRA = 5'd7,
                         OR = 5'd8,   AND = 5'd9,  LUI = 5'd10, AUIPC = 5'd11,
                         JAL = 5'd12, JALR = 5'd13, BEQ = 5'd14, BNE = 5'd15,
                         BLT = 5'd16, BGE = 5'd17, BLTU = 5'd18, BGEU = 5'd19,
                         MUL = 5'd20, MULH = 5'd21, MULHSU = 5'd22, MULHU = 5'd23;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in, in_valid, in_ready, in_len32;
  logic [4:0]  in_op;
  logic [31:0] in_op1, in_op2, in_addr;
  logic [3:0]  in_tag, out_tag;
  logic        out_valid, out_ready, out_zero, out_ovf, out_jalr;
  logic [31:0] out_result, out_jaddr;

  alu_exec_pipe #(.XLEN(32), .TAG_W(4), .OP_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_op1(in_op1),
    .in_op2(in_op2), .in_addr(in_addr), .in_len32(in_len32), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_jalr(out_jalr), .out_jaddr(out_jaddr)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    logic        jalr;
    logic [31:0] jaddr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   w;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive one op and wait (bounded) for its accept edge; optionally score it.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic l32, input logic [3:0] tg,
                      input logic [31:0] er, input logic eo, input logic ej,
                      input logic [31:0] eja, input bit push, output int waits);
    if (push) exp_q.push_back('{tg, er, (er == 32'd0), eo, ej, eja});
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b;
    in_addr = pc; in_len32 = l32; in_tag = tg;
    waits = 0;
    @(negedge clk_in);
    while (!in_ready && waits < 100) begin
      waits++;
      @(negedge clk_in);
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready=%0b expected 1 for tag %0h", in_ready, tg);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tg, input logic [31:0] er, input logic eo);
    send(op, a, b, 32'h0, 1'b1, tg, er, eo, 1'b0, 32'h0, 1'b1, w);
  endtask

  always @(negedge clk_in) begin
    exp_t e;
    if (!rst_in && rdy_in && !flush_in && out_valid && out_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result: observed tag=%0h result=%0h expected none", out_tag, out_result);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_tag", out_tag, e.tag);
        check("out_result", out_result, e.res);
        check("out_zero", out_zero, e.zero);
        check("out_ovf", out_ovf, e.ovf);
        check("out_jalr", out_jalr, e.jalr);
        check("out_jaddr", out_jaddr, e.jaddr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_op = ADD; in_op1 = 32'h1; in_op2 = 32'h1;
    in_addr = 32'h0; in_len32 = 1'b1; in_tag = 4'h0;

    repeat (2) begin
      @(negedge clk_in);
      check("reset_in_ready", in_ready, 1'b0);
      check("reset_out_valid", out_valid, 1'b0);
    end
    tick();
    rst_in = 1'b0; in_valid = 1'b0;
    @(negedge clk_in);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_zero", out_zero, 1'b0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_jalr", out_jalr, 1'b0);
    check("rst_out_jaddr", out_jaddr, 32'h0);
    check("idle_in_ready", in_ready, 1'b1);
    tick();

    out_ready = 1'b1;
    alu(ADD,   32'h7FFF_FFFF, 32'h1,          4'h3, 32'h8000_0000, 1'b1);
    alu(SRA,   32'h8000_0000, 32'h24,         4'h4, 32'hF800_0000, 1'b0);
    send(JALR, 32'h1001, 32'h4, 32'h200, 1'b0, 4'h5, 32'h202, 1'b0, 1'b1, 32'h1004, 1'b1, w);
    alu(SUB,   32'h8000_0000, 32'h1,          4'h6, 32'h7FFF_FFFF, 1'b1);
    alu(ADD,   32'h0,         32'h0,          4'h7, 32'h0,         1'b0);
    alu(SLT,   32'hFFFF_FFFF, 32'h1,          4'h8, 32'h1,         1'b0);
    alu(SLTU,  32'hFFFF_FFFF, 32'h1,          4'h9, 32'h0,         1'b0);
    alu(SLL,   32'h1,         32'h21,         4'hA, 32'h2,         1'b0);
    alu(SRL,   32'h8000_0000, 32'h3F,         4'hB, 32'h1,         1'b0);
    alu(XOR,   32'hF0F0_F0F0, 32'hFF00_FF00,  4'hC, 32'h0FF0_0FF0, 1'b0);
    alu(OR,    32'hF0F0_F0F0, 32'hFF00_FF00,  4'hD, 32'hFFF0_FFF0, 1'b0);
    alu(AND,   32'hF0F0_F0F0, 32'hFF00_FF00,  4'hE, 32'hF000_F000, 1'b0);
    alu(LUI,   32'hDEAD_BEEF, 32'h1234_5000,  4'hF, 32'h1234_5000, 1'b0);
    send(AUIPC, 32'h0, 32'h10, 32'h7FFF_FFF0, 1'b1, 4'h1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 1'b1, w);
    send(JAL,   32'h0, 32'h0,  32'h100,       1'b1, 4'h2, 32'h104,       1'b0, 1'b0, 32'h0, 1'b1, w);
    alu(BEQ,   32'h5,         32'h5,          4'h3, 32'h1,         1'b0);
    alu(BNE,   32'h5,         32'h5,          4'h4, 32'h0,         1'b0);
    alu(BGE,   32'hFFFF_FFFF, 32'h1,          4'h5, 32'h0,         1'b0);
    alu(BLTU,  32'hFFFF_FFFF, 32'h1,          4'h6, 32'h0,         1'b0);
    alu(BGEU,  32'hFFFF_FFFF, 32'h1,          4'h7, 32'h1,         1'b0);
    alu(5'd31, 32'h1234_5678, 32'h1,          4'h8, 32'h0,         1'b0);
`ifndef ALU_MUL_EN
    alu(MUL,   32'h3,         32'h5,          4'h9, 32'h0,         1'b0);
`endif
    repeat (3) tick();

    // Backpressure: result held for three cycles, then delivered exactly once.
    out_ready = 1'b0;
    alu(BLT, 32'hFFFF_FFFF, 32'h1, 4'h5, 32'h1, 1'b0);
    repeat (3) begin
      @(negedge clk_in);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_result", out_result, 32'h1);
      check("hold_out_tag", out_tag, 4'h5);
      check("hold_in_ready", in_ready, 1'b0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk_in);
    tick();
    @(negedge clk_in);
    check("hold_drained_once", out_valid, 1'b0);
    tick();

    // Back-to-back stream with a two-cycle rdy_in stall in the middle.
    for (int i = 0; i < 4; i++) begin
      alu(ADD, 32'h0100_0000 * i, i, 4'(i), 32'h0100_0000 * i + i, 1'b0);
      check("b2b_wait", w, 0);
    end
    rdy_in = 1'b0;
    in_valid = 1'b1; in_op = ADD; in_tag = 4'h4;
    repeat (2) begin
      @(negedge clk_in);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_out_tag", out_tag, 4'h3);
    end
    tick();
    rdy_in = 1'b1;
    for (int i = 4; i < 8; i++) begin
      alu(ADD, 32'h0100_0000 * i, i, 4'(i), 32'h0100_0000 * i + i, 1'b0);
      check("b2b_wait", w, 0);
    end
    repeat (3) tick();

    // Flush discards a held result and blocks the concurrent offer.
    out_ready = 1'b0;
    send(ADD, 32'h1, 32'h2, 32'h0, 1'b1, 4'h9, 32'h3, 1'b0, 1'b0, 32'h0, 1'b0, w);
    flush_in = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_op = ADD; in_tag = 4'hA;
    @(negedge clk_in);
    check("flush_in_ready", in_ready, 1'b0);
    tick();
    flush_in = 1'b0; in_valid = 1'b0;
    @(negedge clk_in);
    check("flush_out_valid", out_valid, 1'b0);
    tick();
    alu(ADD, 32'h10, 32'h20, 4'hB, 32'h30, 1'b0);
    check("post_flush_wait", w, 0);
    repeat (3) tick();

`ifdef ALU_MUL_EN
    alu(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h1, 32'hFFFF_FFFE, 1'b0);
    k = 0;
    do begin
      @(negedge clk_in);
      k++;
      if (k == 5) check("busy_in_ready", in_ready, 1'b0);
    end while (!out_valid && k < 100);
    check("mul_latency", k, 33);
    tick();
    alu(MUL,    32'hFFFF_FFFD, 32'h5,         4'h2, 32'hFFFF_FFF1, 1'b0);
    alu(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h3, 32'h0,         1'b0);
    alu(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h4, 32'hFFFF_FFFF, 1'b0);
    repeat (40) tick();
    send(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'h5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, w);
    repeat (9) tick();
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    alu(ADD, 32'h1, 32'h1, 4'h6, 32'h2, 1'b0);
    check("mul_flush_accept_wait", w, 0);
    repeat (40) tick();
`endif

    @(negedge clk_in);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
